// File: rtl/timer_counter.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising IRQ on expiry, one-shot or periodic.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (PRESCALE clocks per COUNT decrement).
module timer_counter #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_pending;
    logic        tick;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        load_count;
    logic        dec_count;
    logic        expire;
    logic        clr_enable;
    logic        clr_pending;

    assign wr_ctrl   = WE && (Addr[3:2] == 2'd0);
    assign wr_preset = WE && (Addr[3:2] == 2'd1);

`ifdef TIMER_PRESCALE_EN
    localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
    logic [15:0] psc;

    always_ff @(posedge clk) begin
        if (reset) begin
            psc <= 16'd0;
        end else if (state == S_IDLE || state == S_LOAD) begin
            psc <= 16'd0;
        end else if (state == S_CNT) begin
            psc <= tick ? 16'd0 : psc + 16'd1;
        end
    end

    assign tick = (psc == PSC_LAST);

    logic unused_bits;
    assign unused_bits = ^{Addr[31:4], Addr[1:0]};
`else
    assign tick = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{Addr[31:4], Addr[1:0], (PRESCALE != 0)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (ctrl[0]) state_next = S_LOAD;
            S_LOAD: state_next = S_CNT;
            S_CNT: begin
                if (!ctrl[0]) begin
                    state_next = S_IDLE;
                end else if (tick && count <= 32'd1) begin
                    state_next = S_INT;
                end
            end
            S_INT:  state_next = (ctrl[2:1] == 2'b01) ? S_LOAD : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_count  = 1'b0;
        dec_count   = 1'b0;
        expire      = 1'b0;
        clr_enable  = 1'b0;
        clr_pending = 1'b0;
        case (state)
            S_LOAD: load_count = 1'b1;
            S_CNT: begin
                if (ctrl[0] && tick) begin
                    if (count > 32'd1) begin
                        dec_count = 1'b1;
                    end else begin
                        expire = 1'b1;
                    end
                end
            end
            S_INT: begin
                if (ctrl[2:1] == 2'b01) begin
                    clr_pending = 1'b1;
                end else begin
                    clr_enable = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus writes take priority over the FSM's Enable clear; the FSM's pending set beats any clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl        <= 4'd0;
            preset      <= 32'd0;
            count       <= 32'd0;
            irq_pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= Din[3:0];
            end else if (clr_enable) begin
                ctrl[0] <= 1'b0;
            end

            if (wr_preset) begin
                preset <= Din;
            end

            if (load_count) begin
                count <= preset;
            end else if (dec_count) begin
                count <= count - 32'd1;
            end else if (expire) begin
                count <= 32'd0;
            end

            if (expire) begin
                irq_pending <= 1'b1;
            end else if (wr_ctrl || wr_preset || clr_pending) begin
                irq_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, ctrl};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl[3] & irq_pending;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped countdown timer on the CPU bridge bus, directly upstream of the CP0 interrupt logic.
- IRQ drives one HWInt bit of CP0, by convention HWInt[0], which CP0 gates with SR[10].
- Software programs preset value, mode and interrupt mask through word registers.
- The block counts down and raises IRQ on expiry, either as a one-shot or as a periodic auto-reload timer.

Parameters:
- PRESCALE, 4, clock cycles per COUNT decrement. Used only when TIMER_PRESCALE_EN is defined. Legal values are 1 to 65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  32  byte address; only Addr[3:2] is decoded. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- WE  input  1  write enable for the decoded register.
- Din  input  32  write data.
- Dout  output  32  combinational read data for the decoded register.
- IRQ  output  1  interrupt request to CP0 HWInt.

Behaviour:
- Registers:
  - CTRL: [0] Enable, [2:1] Mode, [3] IM (interrupt mask); [31:4] read 0.
  - PRESET: 32 bits, read/write.
  - COUNT: 32 bits, read-only; writes are ignored.
  - Reserved address reads 0.
- CTRL write stores Din[3:0] and zeroes the upper bits.
- Reset values: CTRL=0, PRESET=0, COUNT=0, irq_pending=0, prescale counter=0, state=IDLE, IRQ=0. Dout reflects reset register values.
- IRQ = CTRL[3] & irq_pending, a pure combinational AND of registered values.
- FSM states, evaluated each clock edge when reset=0:
  - IDLE: if Enable=1, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - Enable=0: go to IDLE, COUNT frozen.
    - Else if COUNT > 1: COUNT <= COUNT - 1.
    - Else (COUNT is 0 or 1): COUNT <= 0, irq_pending <= 1, go to INT.
  - INT:
    - Mode 01 (periodic): irq_pending <= 0, go to LOAD.
    - Any other mode (one-shot): CTRL[0] <= 0, go to IDLE; irq_pending stays 1.
- Timing, with PRESET = N >= 1 and Enable written at edge E0:
  - LOAD at E1, COUNT = N at E2, COUNT = N-k at E(2+k).
  - INT entered at E(N+2).
  - N = 0 behaves like N = 1: INT at E3.
- One-shot IRQ: stays high until a write to CTRL or PRESET clears irq_pending.
- Periodic IRQ: exactly one cycle wide (the INT state); period is N+2 cycles.
- Arithmetic is unsigned 32-bit; COUNT never wraps below 0.
- Simultaneous events:
  - A bus write to CTRL on the same edge the FSM clears Enable: the bus write wins, and the FSM's clear is dropped.
  - A write clearing irq_pending on the same edge the FSM sets it: the set wins.
  - A PRESET write during CNT does not affect the current COUNT; it takes effect at the next LOAD.
- Clearing Enable mid-count: the FSM returns to IDLE and COUNT holds its value. Re-enabling reloads from PRESET; it does not resume.
- Reset mid-operation: all state returns to reset values on that edge. IRQ is 0 the following cycle.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - In CNT, COUNT decrements only when a 16-bit prescale counter reaches PRESCALE-1; the counter then wraps to 0.
  - The prescale counter is cleared in LOAD and IDLE.
  - The expiry check (COUNT <= 1) is also gated by the prescale tick.
  - INT is entered at E(N*PRESCALE + 2) for N >= 1.
- Undefined: the block decrements every cycle, and the prescale counter logic is absent.

Test Plan:
- Reset then read all addresses -> Dout = 0 at 0x0, 0x4, 0x8 and 0xC; IRQ = 0.
- One-shot with interrupt enabled: write PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1 on consecutive cycles; IRQ rises 7 cycles after the CTRL write edge and stays high; CTRL reads 0x8. Then write CTRL=0x8 -> IRQ = 0 next cycle.
- Periodic: write PRESET=3, then CTRL=0xB -> IRQ is a 1-cycle pulse every 5 cycles for at least 4 periods; Enable stays 1.
- Masked: write PRESET=2, then CTRL=0x1 -> expiry reached, irq_pending set internally, IRQ stays 0. A later CTRL=0x8 write clears pending, so IRQ stays 0.
- Disable mid-count: PRESET=10, enable, then write CTRL=0x0 when COUNT=6 -> COUNT holds at 6 and no IRQ. Re-enable -> COUNT reloads to 10.
- Reset mid-count: assert reset while COUNT=4 -> next cycle COUNT=0, CTRL=0, IRQ=0. With TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2 -> IRQ at E10.
